// File: rtl/pa_soc_uart_txq.sv
// Two-requester byte queue that feeds a memory-mapped UART: round-robin push, FIFO, TXD write / status poll / clear FSM.
// Optional poll timeout with sticky error flag: define UART_TXQ_TIMEOUT_EN.
module pa_soc_uart_txq #(
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] POLL_TIMEOUT = 32'd200000
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          req0_valid_i,
    input  logic [7:0]                    req0_data_i,
    output logic                          req0_ready_o,
    input  logic                          req1_valid_i,
    input  logic [7:0]                    req1_data_i,
    output logic                          req1_ready_o,
    output logic [7:0]                    uart_addr_o,
    output logic                          uart_rd_o,
    output logic                          uart_we_o,
    output logic [31:0]                   uart_data_o,
    input  logic [31:0]                   uart_data_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          err_o,
    input  logic                          err_clr_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, WR_TXD, POLL, CLR} state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] cnt_q;
    logic          rr_q;  // 1: req1 preferred on a tie
    logic          full, empty, gnt0, gnt1, push, pop, tmo_hit;
    logic [7:0]    push_data;

    // Arbiter: a tie goes to whoever was not served last
    assign gnt0         = req0_valid_i & (~req1_valid_i | ~rr_q);
    assign gnt1         = req1_valid_i & (~req0_valid_i |  rr_q);
    assign full         = (cnt_q == LW'(FIFO_DEPTH));
    assign empty        = (cnt_q == '0);
    assign req0_ready_o = gnt0 & ~full;
    assign req1_ready_o = gnt1 & ~full;
    assign push         = req0_ready_o | req1_ready_o;
    assign push_data    = req1_ready_o ? req1_data_i : req0_data_i;
    assign pop          = (state_q == WR_TXD);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_q   <= 1'b0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                rr_q   <= req0_ready_o;
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop)
                rptr_q <= rptr_q + 1'b1;
            if (push && !pop)
                cnt_q <= cnt_q + 1'b1;
            else if (pop && !push)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wptr_q] <= push_data;
    end

    assign level_o = cnt_q;
    assign busy_o  = (state_q != IDLE) | ~empty;

`ifdef UART_TXQ_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        err_q;

    // Counter restarts on every POLL entry, which always comes from WR_TXD
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            tmo_q <= '0;
        else if (state_q == WR_TXD)
            tmo_q <= '0;
        else if (state_q == POLL)
            tmo_q <= tmo_q + 32'd1;
    end

    assign tmo_hit = (tmo_q == POLL_TIMEOUT - 32'd1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            err_q <= 1'b0;
        else if (state_q == POLL && !uart_data_i[0] && tmo_hit)
            err_q <= 1'b1;
        else if (err_clr_i)
            err_q <= 1'b0;
    end

    assign err_o = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = err_clr_i ^ (^POLL_TIMEOUT);
    assign tmo_hit    = 1'b0;
    assign err_o      = 1'b0;
`endif

    logic unused_rd_bits;
    assign unused_rd_bits = ^uart_data_i[31:1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = WR_TXD;
            WR_TXD:  state_d = POLL;
            POLL: begin
                // Completion wins over a timeout landing in the same cycle
                if (uart_data_i[0])
                    state_d = CLR;
                else if (tmo_hit)
                    state_d = IDLE;
            end
            CLR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        uart_addr_o = 8'h00;
        uart_rd_o   = 1'b0;
        uart_we_o   = 1'b0;
        uart_data_o = 32'h0;
        case (state_q)
            WR_TXD: begin
                uart_we_o   = 1'b1;
                uart_addr_o = 8'h10;
                uart_data_o = {24'b0, mem_q[rptr_q]};
            end
            POLL: begin
                uart_rd_o   = 1'b1;
                uart_addr_o = 8'h04;
            end
            CLR: begin
                uart_we_o   = 1'b1;
                uart_addr_o = 8'h04;
                uart_data_o = 32'h1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pa_soc_uart_txq.sv
// Scoreboard bench for pa_soc_uart_txq: stimulus queues expected TXD bytes, a negedge monitor checks UART traffic.
module tb_pa_soc_uart_txq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0]  req0_data, req1_data;
    logic [7:0]  uart_addr;
    logic        uart_rd, uart_we;
    logic [31:0] uart_wdata, uart_rdata;
    logic        busy, err, err_clr;
    logic [3:0]  level;

    int          tests = 0, fails = 0;
    logic [7:0]  exp_q[$];
    int          clr_cnt = 0, acc_cnt = 0, poll_cnt;
    int          sr_delay = 10;
    logic        hold = 1'b0, chk_rd = 1'b0;

    always #5 clk = ~clk;

    pa_soc_uart_txq #(.FIFO_DEPTH(8), .POLL_TIMEOUT(32'd16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_ready_o(req0_ready),
        .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_ready_o(req1_ready),
        .uart_addr_o(uart_addr), .uart_rd_o(uart_rd), .uart_we_o(uart_we),
        .uart_data_o(uart_wdata), .uart_data_i(uart_rdata),
        .busy_o(busy), .level_o(level), .err_o(err), .err_clr_i(err_clr)
    );

    // UART model: SR[0] rises on the sr_delay-th poll read of a byte unless held
    assign uart_rdata = {31'b0, (!hold && (poll_cnt + 1 >= sr_delay))};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              poll_cnt <= 0;
        else if (uart_we && uart_addr == 8'h10)  poll_cnt <= 0;
        else if (uart_rd)                        poll_cnt <= poll_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (uart_we || uart_rd) acc_cnt++;
            if (uart_rd) chk("poll_addr", uart_addr, 8'h04);
            if (uart_we && uart_addr == 8'h10) begin
                chk("txd_no_rd", uart_rd, 1'b0);
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL txd_unexpected: got %0h expected none", uart_wdata);
                end else
                    chk("txd_data", uart_wdata, {24'b0, exp_q.pop_front()});
            end
            if (uart_we && uart_addr == 8'h04) begin
                clr_cnt++;
                chk("clr_data", uart_wdata, 32'h1);
                if (chk_rd) chk("poll_len", poll_cnt, sr_delay);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
        err_clr = 0; hold = 0; exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk); #1;
        while (busy && n < 300) begin @(negedge clk); #1; n++; end
        chk(nm, busy, 1'b0);
        chk({nm, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic push0(input logic [7:0] d, input string nm);
        @(negedge clk);
        req0_valid = 1; req0_data = d; exp_q.push_back(d);
        #1 chk(nm, req0_ready, 1'b1);
    endtask

    initial begin
        int n, c0, a0;
        rst_n = 0; req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0; err_clr = 0;
        #1;
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_uart", {uart_rd, uart_we, uart_addr, uart_wdata}, 0);
        do_reset();

        // Single byte, 10 poll cycles
        sr_delay = 10; chk_rd = 1;
        push0(8'h55, "single_ready");
        @(negedge clk) req0_valid = 0;
        wait_idle("single_idle");
        chk("single_clr", clr_cnt, 1);
        chk("single_uart_off", {uart_rd, uart_we, uart_addr, uart_wdata}, 0);

        // Contention: tie alternates starting with req0 after reset
        do_reset(); sr_delay = 1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'hA0 + 8'(k));
            exp_q.push_back(8'hB0 + 8'(k));
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req0_valid = 1; req1_valid = 1;
            req0_data = 8'hA0 + 8'(k / 2); req1_data = 8'hB0 + 8'(k / 2);
            #1;
            chk("rr_ready0", req0_ready, (k % 2) == 0);
            chk("rr_ready1", req1_ready, (k % 2) == 1);
        end
        @(negedge clk) begin req0_valid = 0; req1_valid = 0; end
        wait_idle("rr_idle");

        // Full: SR held low, 9 accepted (first one pops), 10th blocked
        do_reset(); chk_rd = 0; hold = 1;
        for (int k = 0; k < 9; k++) push0(8'hC0 + 8'(k), "full_push_ready");
        @(negedge clk);
        req0_data = 8'hC9; req1_valid = 1; req1_data = 8'hEE; exp_q.push_back(8'hC9);
        #1;
        chk("full_level", level, 8);
        chk("full_ready0", req0_ready, 1'b0);
        chk("full_ready1", req1_ready, 1'b0);
        chk("full_no_err", err, 1'b0);
        req1_valid = 0; hold = 0; n = 0;
        while (!req0_ready && n < 50) begin @(negedge clk); #1; n++; end
        chk("full_retry_ready", req0_ready, 1'b1);
        @(negedge clk) req0_valid = 0;
        wait_idle("full_idle");

        // Push during WR_TXD with three queued keeps level at 3
        do_reset(); hold = 1;
        for (int k = 0; k < 4; k++) push0(8'h31 + 8'(k), "pp_push_ready");
        @(negedge clk) req0_valid = 0;
        #1 chk("pp_level_pre", level, 3);
        hold = 0; n = 0;
        while (!(uart_we && uart_addr == 8'h10) && n < 50) begin @(negedge clk); #1; n++; end
        chk("pp_level_at_txd", level, 3);
        req0_valid = 1; req0_data = 8'h35; exp_q.push_back(8'h35);
        @(negedge clk) req0_valid = 0;
        #1 chk("pp_level_post", level, 3);
        wait_idle("pp_idle");

        // Reset mid-POLL with three bytes queued
        do_reset(); hold = 1;
        for (int k = 0; k < 4; k++) push0(8'h61 + 8'(k), "mr_push_ready");
        @(negedge clk) req0_valid = 0;
        repeat (3) @(negedge clk);
        #1 chk("mr_in_poll", uart_rd, 1'b1);
        c0 = clr_cnt;
        rst_n = 0; #1;
        chk("mr_uart_off", {uart_rd, uart_we, uart_addr, uart_wdata}, 0);
        chk("mr_level", level, 0);
        chk("mr_busy", busy, 0);
        exp_q.delete(); hold = 0;
        @(negedge clk) rst_n = 1;
        a0 = acc_cnt;
        repeat (20) @(negedge clk);
        chk("mr_quiet", acc_cnt, a0);
        chk("mr_no_clr", clr_cnt, c0);
        push0(8'h70, "mr_new_ready");
        @(negedge clk) req0_valid = 0;
        wait_idle("mr_idle");
        chk("mr_new_clr", clr_cnt, c0 + 1);

`ifdef UART_TXQ_TIMEOUT_EN
        // Timeout after 16 poll cycles, no CLR, next byte proceeds
        do_reset(); hold = 1; sr_delay = 1;
        c0 = clr_cnt;
        push0(8'h41, "tmo_push_ready");
        push0(8'h42, "tmo_push2_ready");
        @(negedge clk) req0_valid = 0;
        n = 0;
        while (!err && n < 100) begin @(negedge clk); #1; n++; end
        chk("tmo_err_set", err, 1'b1);
        chk("tmo_poll_len", poll_cnt, 16);
        chk("tmo_no_clr", clr_cnt, c0);
        hold = 0;
        wait_idle("tmo_idle");
        chk("tmo_next_clr", clr_cnt, c0 + 1);
        chk("tmo_err_sticky", err, 1'b1);
        @(negedge clk) err_clr = 1;
        @(negedge clk) err_clr = 0;
        #1 chk("tmo_err_clr", err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
